maindec_mc_hs: RTL

Parametrised multicycle main-decoder FSM for the 4-bit-opcode CPU controller. It drives the datapath control strobes per state. Additions over the base decoder: an ADI (add-immediate) path, a JAL link writeback, a HALT state, and a mem_req/mem_ready handshake that stalls FETCH/MEMRD/MEMWR until memory responds. It sits in the controller beside the ALU decoder.

---
 rtl/maindec_mc_hs.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/maindec_mc_hs.sv
// Multicycle main decoder with ADI, JAL link, HALT and a mem_req/mem_ready stall handshake.
// Optional MAINDEC_ILLEGAL_TRAP_EN: undefined opcodes trap to HALT and set a sticky illegal_op.
module maindec_mc_hs #(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned ALUOP_W = 2,
  parameter logic [3:0]  OP_ADI  = 4'b1000,
  parameter logic [3:0]  OP_HLT  = 4'b1111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic               branch,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               link,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               mem_req,
  output logic               halted,
  output logic               illegal_op,
  output logic [4:0]         state
);

  typedef enum logic [4:0] {
    S_FETCH   = 5'h00,
    S_DECODE  = 5'h01,
    S_MEMADR  = 5'h02,
    S_MEMRD   = 5'h03,
    S_MEMWB   = 5'h04,
    S_MEMWR   = 5'h05,
    S_EXECUTE = 5'h06,
    S_ALUWB   = 5'h07,
    S_BRANCH  = 5'h08,
    S_ADIEX   = 5'h09,
    S_ADIWB   = 5'h0A,
    S_JUMP    = 5'h0B,
    S_HALT    = 5'h0C
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       link;
    logic       mem_req;
    logic       halted;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctl_t;

  localparam logic [OP_W-1:0] OPC_RMAX = OP_W'(3);
  localparam logic [OP_W-1:0] OPC_LW   = OP_W'(4);
  localparam logic [OP_W-1:0] OPC_SW   = OP_W'(5);
  localparam logic [OP_W-1:0] OPC_BEQ  = OP_W'(6);
  localparam logic [OP_W-1:0] OPC_JAL  = OP_W'(7);
  localparam logic [OP_W-1:0] OPC_ADI  = OP_W'(OP_ADI);
  localparam logic [OP_W-1:0] OPC_HLT  = OP_W'(OP_HLT);

  // Moore part of the control word; the mem_ready-qualified strobes are added at the outputs.
  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_req = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_ALUWB:   begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      S_BRANCH:  begin c.alusrca = 1'b1; c.branch = 1'b1; c.pcsrc = 2'b01; c.aluop = 2'b01; end
      S_ADIEX:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADIWB:   c.regwrite = 1'b1;
      S_JUMP:    begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; c.regwrite = 1'b1; c.link = 1'b1; end
      S_HALT:    c.halted = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctl_t   ctl_q;
`ifdef MAINDEC_ILLEGAL_TRAP_EN
  logic   illegal_q;
  logic   trap_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef MAINDEC_ILLEGAL_TRAP_EN
    trap_d  = 1'b0;
`endif
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op <= OPC_RMAX)                   state_d = S_EXECUTE;
        else if (op == OPC_LW || op == OPC_SW) state_d = S_MEMADR;
        else if (op == OPC_BEQ)               state_d = S_BRANCH;
        else if (op == OPC_JAL)               state_d = S_JUMP;
        else if (op == OPC_ADI)               state_d = S_ADIEX;
        else if (op == OPC_HLT)               state_d = S_HALT;
        else begin
`ifdef MAINDEC_ILLEGAL_TRAP_EN
          state_d = S_HALT;
          trap_d  = 1'b1;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_MEMADR:  state_d = (op == OPC_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADIEX:   state_d = S_ADIWB;
      S_ADIWB:   state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // Control word is registered from the next state so it lines up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctl_q     <= decode_ctl(S_FETCH);
`ifdef MAINDEC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctl_q     <= decode_ctl(state_d);
`ifdef MAINDEC_ILLEGAL_TRAP_EN
      if (trap_d) illegal_q <= 1'b1;
`endif
    end
  end

  assign pcwrite  = ctl_q.pcwrite | ((state_q == S_FETCH) & mem_ready);
  assign irwrite  = (state_q == S_FETCH) & mem_ready;
  assign memwrite = (state_q == S_MEMWR) & mem_ready;
  assign regwrite = ctl_q.regwrite;
  assign alusrca  = ctl_q.alusrca;
  assign branch   = ctl_q.branch;
  assign iord     = ctl_q.iord;
  assign memtoreg = ctl_q.memtoreg;
  assign regdst   = ctl_q.regdst;
  assign link     = ctl_q.link;
  assign alusrcb  = ctl_q.alusrcb;
  assign pcsrc    = ctl_q.pcsrc;
  assign aluop    = ALUOP_W'(ctl_q.aluop);
  assign mem_req  = ctl_q.mem_req;
  assign halted   = ctl_q.halted;
  assign state    = state_q;
`ifdef MAINDEC_ILLEGAL_TRAP_EN
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
